// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind uart_rx: SOF / length / payload framing with buffered, valid-ready output.
// Defining UART_PKT_CKSUM_EN adds a trailing XOR checksum byte and its CKSUM check state.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SOF         = 8'h7E,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic [7:0] drop_cnt
);
    localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int               TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       ERR_LEN   = 2'b01;
    localparam logic [1:0]       ERR_TMO   = 2'b11;
`ifdef UART_PKT_CKSUM_EN
    localparam logic [1:0]       ERR_CKSUM = 2'b10;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
`ifdef UART_PKT_CKSUM_EN
        S_CKSUM,
`endif
        S_DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic             rx_done_q;
    logic [7:0]       len_q, len_nxt;
    logic [IDX_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [IDX_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic             pkt_ok_nxt, pkt_err_nxt;
    logic [1:0]       err_code_nxt;
    logic [7:0]       drop_cnt_nxt;
    logic             buf_we;
    logic             byte_acc;
    logic             timed;
    logic [7:0]       pkt_buf [MAX_LEN];
`ifdef UART_PKT_CKSUM_EN
    logic [7:0]       xor_q, xor_nxt;
`endif

    // Rising edge of rx_done takes exactly one byte whether uart_rx pulses or holds the flag.
    assign byte_acc = rx_done && !rx_done_q;

`ifdef UART_PKT_CKSUM_EN
    assign timed = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CKSUM);
`else
    assign timed = (state == S_LEN) || (state == S_PAYLOAD);
`endif

    assign out_valid = (state == S_DRAIN);
    assign out_data  = out_valid ? pkt_buf[rd_ptr] : 8'd0;
    assign out_last  = out_valid && (8'(rd_ptr) == len_q - 8'd1);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt    = state;
        len_nxt      = len_q;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        pkt_ok_nxt   = 1'b0;
        pkt_err_nxt  = 1'b0;
        err_code_nxt = err_code;
        drop_cnt_nxt = drop_cnt;
        buf_we       = 1'b0;
        tmo_nxt      = '0;
`ifdef UART_PKT_CKSUM_EN
        xor_nxt      = xor_q;
`endif
        if (timed && !byte_acc) tmo_nxt = tmo_cnt + 1'b1;

        case (state)
            S_IDLE: begin
                if (byte_acc && rx_data == SOF) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (byte_acc) begin
                    if (rx_data != 8'd0 && rx_data <= MAX_LEN_B) begin
                        len_nxt    = rx_data;
                        wr_ptr_nxt = '0;
`ifdef UART_PKT_CKSUM_EN
                        xor_nxt    = rx_data;
`endif
                        state_nxt  = S_PAYLOAD;
                    end else begin
                        pkt_err_nxt  = 1'b1;
                        err_code_nxt = ERR_LEN;
                        state_nxt    = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (byte_acc) begin
                    buf_we     = 1'b1;
                    wr_ptr_nxt = wr_ptr + 1'b1;
`ifdef UART_PKT_CKSUM_EN
                    xor_nxt    = xor_q ^ rx_data;
`endif
                    if (8'(wr_ptr) == len_q - 8'd1) begin
`ifdef UART_PKT_CKSUM_EN
                        state_nxt  = S_CKSUM;
`else
                        pkt_ok_nxt = 1'b1;
                        rd_ptr_nxt = '0;
                        state_nxt  = S_DRAIN;
`endif
                    end
                end
            end
`ifdef UART_PKT_CKSUM_EN
            S_CKSUM: begin
                if (byte_acc) begin
                    if ((rx_data ^ xor_q) == 8'd0) begin
                        pkt_ok_nxt = 1'b1;
                        rd_ptr_nxt = '0;
                        state_nxt  = S_DRAIN;
                    end else begin
                        pkt_err_nxt  = 1'b1;
                        err_code_nxt = ERR_CKSUM;
                        state_nxt    = S_IDLE;
                    end
                end
            end
`endif
            S_DRAIN: begin
                // Bytes arriving while the buffer is still being read out are counted and dropped.
                if (byte_acc && drop_cnt != 8'hFF) drop_cnt_nxt = drop_cnt + 8'd1;
                if (out_ready) begin
                    rd_ptr_nxt = rd_ptr + 1'b1;
                    if (out_last) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // An accepted byte in the expiry cycle takes precedence over the timeout.
        if (timed && !byte_acc && tmo_cnt == TMO_LAST) begin
            pkt_err_nxt  = 1'b1;
            err_code_nxt = ERR_TMO;
            state_nxt    = S_IDLE;
            tmo_nxt      = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rx_done_q <= 1'b0;
            len_q     <= 8'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tmo_cnt   <= '0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= 2'b00;
            drop_cnt  <= 8'd0;
`ifdef UART_PKT_CKSUM_EN
            xor_q     <= 8'd0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
            state     <= state_nxt;
            rx_done_q <= rx_done;
            len_q     <= len_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            tmo_cnt   <= tmo_nxt;
            pkt_ok    <= pkt_ok_nxt;
            pkt_err   <= pkt_err_nxt;
            err_code  <= err_code_nxt;
            drop_cnt  <= drop_cnt_nxt;
`ifdef UART_PKT_CKSUM_EN
            xor_q     <= xor_nxt;
`endif
        end
    end

    // NOTE: the payload buffer has no reset; it is only read while out_valid is high, after a fresh fill.
    always_ff @(posedge clk) begin
        if (buf_we) pkt_buf[wr_ptr] <= rx_data;
    end
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: frame-level reference model feeds queues, a monitor checks outputs.
module tb_uart_rx_pkt_ctrl;
    localparam int MAX_LEN     = 16;
    localparam int TIMEOUT_CYC = 512;
`ifdef UART_PKT_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    typedef struct packed { logic [7:0] d; logic last; } exp_byte_t;
    typedef struct packed { logic ok; logic [1:0] code; } exp_evt_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic [7:0] drop_cnt;

    exp_byte_t exp_bytes[$];
    exp_evt_t  exp_evt[$];
    int        n_checks = 0;
    int        n_fail = 0;
    int        drop_model = 0;
    int        ready_mode = 1;

    uart_rx_pkt_ctrl #(.SOF(8'h7E), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT presented an output, scoreboard expected none", name);
    endtask

    // Consumer ready: 0 = held low, 1 = held high, otherwise random each cycle.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT strobes or completes a handshake.
    initial begin
        logic       prev_stall, prev_valid, prev_last;
        logic [7:0] prev_data;
        exp_evt_t   e;
        exp_byte_t  b;
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        prev_last  = 1'b0;
        prev_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (pkt_ok || pkt_err) begin
                    if (exp_evt.size() == 0) unexpected("strobe");
                    else begin
                        e = exp_evt.pop_front();
                        check("pkt_ok", 32'(pkt_ok), 32'(e.ok));
                        check("pkt_err", 32'(pkt_err), 32'(!e.ok));
                        if (!e.ok) check("err_code", 32'(err_code), 32'(e.code));
                    end
                end
                if (out_valid && !prev_valid) check("valid_rise_with_pkt_ok", 32'(pkt_ok), 32'd1);
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(prev_data));
                    check("hold_last", 32'(out_last), 32'(prev_last));
                end
                if (out_valid && out_ready) begin
                    if (exp_bytes.size() == 0) unexpected("out_byte");
                    else begin
                        b = exp_bytes.pop_front();
                        check("out_data", 32'(out_data), 32'(b.d));
                        check("out_last", 32'(out_last), 32'(b.last));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_valid = out_valid;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_done = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    // Reference model at frame level: decides the outcome from length, XOR sum and truncation.
    task automatic send_frame(input int len, input logic [7:0] pl[$], input bit bad_ck, input int n_sent);
        exp_evt_t   e;
        exp_byte_t  b;
        logic [7:0] ck;
        ck = 8'(len);
        foreach (pl[i]) ck ^= pl[i];
        if (bad_ck) ck ^= 8'h5A;
        if (len < 1 || len > MAX_LEN) begin
            e.ok = 1'b0; e.code = 2'b01; exp_evt.push_back(e);
            send_byte(8'h7E);
            send_byte(8'(len));
            return;
        end
        if (n_sent < len) begin
            e.ok = 1'b0; e.code = 2'b11; exp_evt.push_back(e);
        end else if (CK_EN && bad_ck) begin
            e.ok = 1'b0; e.code = 2'b10; exp_evt.push_back(e);
        end else begin
            e.ok = 1'b1; e.code = 2'b00; exp_evt.push_back(e);
            for (int i = 0; i < len; i++) begin
                b.d = pl[i]; b.last = (i == len - 1); exp_bytes.push_back(b);
            end
        end
        send_byte(8'h7E);
        send_byte(8'(len));
        for (int i = 0; i < n_sent; i++) send_byte(pl[i]);
        if (CK_EN && n_sent == len) send_byte(ck);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_bytes.size() != 0 || exp_evt.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completes"}, 32'(n < 3000), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] g;
        exp_evt_t   e;
        int         n, got, len, kind, n_sent, stale;
        reset = 1'b1; rx_data = 8'd0; rx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_pkt_ok", 32'(pkt_ok), 32'd0);
        check("rst_pkt_err", 32'(pkt_err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        reset = 1'b0;

        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(3, pl, 1'b0, 3);
        wait_idle("good_pkt");
`ifdef UART_PKT_CKSUM_EN
        send_frame(3, pl, 1'b1, 3);
        wait_idle("bad_cksum");
        send_frame(3, pl, 1'b0, 3);
        wait_idle("good_after_bad_cksum");
`endif
        pl.delete();
        send_frame(0, pl, 1'b0, 0);
        wait_idle("bad_len_0");
        send_frame(17, pl, 1'b0, 0);
        wait_idle("bad_len_17");
        pl = '{8'h5C};
        send_frame(1, pl, 1'b0, 1);
        wait_idle("len_1");
        pl.delete();
        for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'(i * 37 + 5));
        send_frame(MAX_LEN, pl, 1'b0, MAX_LEN);
        wait_idle("len_max");

        // Timeout: pkt_err must appear exactly TIMEOUT_CYC edges after the edge that takes byte 11.
        e.ok = 1'b0; e.code = 2'b11; exp_evt.push_back(e);
        send_byte(8'h7E);
        send_byte(8'h02);
        @(posedge clk);
        #1;
        rx_data = 8'h11; rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        n = 0; got = 0;
        while (got == 0 && n < 2 * TIMEOUT_CYC) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = int'(pkt_err);
        end
        check("timeout_latency", 32'(n), 32'(TIMEOUT_CYC));
        wait_idle("timeout");

        // Backpressure with one overrun byte during DRAIN.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(3, pl, 1'b0, 3);
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        check("ovr_valid", 32'(out_valid), 32'd1);
        send_byte(8'hA5);
        drop_model++;
        repeat (3) @(negedge clk);
        check("ovr_drop_cnt", 32'(drop_cnt), 32'(drop_model));
        check("ovr_hold_data", 32'(out_data), 32'h11);
        ready_mode = 1;
        wait_idle("overrun");

        // Saturate drop_cnt, then reset while the packet is still presented.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        pl = '{8'hC3};
        send_frame(1, pl, 1'b0, 1);
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hA5);
            if (drop_model < 255) drop_model++;
        end
        repeat (2) @(negedge clk);
        check("sat_drop_cnt", 32'(drop_cnt), 32'(drop_model));
        check("sat_data", 32'(out_data), 32'hC3);
        check("sat_last", 32'(out_last), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_err_code", 32'(err_code), 32'd0);
        check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        exp_bytes.delete();
        exp_evt.delete();
        drop_model = 0;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_after_reset", 32'(stale), 32'd0);

        // Randomized traffic with random consumer stalls.
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'h7E) g = 8'h00;
                send_byte(g);
            end
            kind = $urandom_range(0, 99);
            if (kind < 10) len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
            else len = $urandom_range(1, MAX_LEN);
            pl.delete();
            if (len >= 1 && len <= MAX_LEN)
                for (int j = 0; j < len; j++) pl.push_back(8'($urandom_range(0, 255)));
            n_sent = len;
            if (i % 13 == 5 && len >= 1 && len <= MAX_LEN) n_sent = $urandom_range(0, len - 1);
            send_frame(len, pl, (kind >= 10 && kind < 25), n_sent);
            wait_idle("random");
        end

        check("exp_bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("exp_evt_left", 32'(exp_evt.size()), 32'd0);
        check("final_drop_cnt", 32'(drop_cnt), 32'(drop_model));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
